// File: rtl/multi_cycle_control_fsm_pkg.sv
// Shared constants for the multi-cycle MIPS control FSM:
// opcodes, state codes, ALU/mux selects and the opcode class bundle.
package mc_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SUB   = 4'b0001;
  localparam logic [3:0] ALU_RTYPE = 4'b0010;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_IMMS = 2'b11;

  localparam logic [1:0] PCS_ALU    = 2'b00;
  localparam logic [1:0] PCS_ALUOUT = 2'b01;
  localparam logic [1:0] PCS_JUMP   = 2'b10;

  localparam logic [3:0] S_RST       = 4'd0;
  localparam logic [3:0] S_FETCH     = 4'd1;
  localparam logic [3:0] S_DECODE    = 4'd2;
  localparam logic [3:0] S_MEM_ADDR  = 4'd3;
  localparam logic [3:0] S_MEM_READ  = 4'd4;
  localparam logic [3:0] S_MEM_WB    = 4'd5;
  localparam logic [3:0] S_MEM_WRITE = 4'd6;
  localparam logic [3:0] S_R_EXEC    = 4'd7;
  localparam logic [3:0] S_R_WB      = 4'd8;
  localparam logic [3:0] S_I_EXEC    = 4'd9;
  localparam logic [3:0] S_I_WB      = 4'd10;
  localparam logic [3:0] S_BRANCH    = 4'd11;
  localparam logic [3:0] S_JUMP      = 4'd12;
  localparam logic [3:0] S_ILLEGAL   = 4'd13;

  typedef struct packed {
    logic rtype;
    logic lw;
    logic sw;
    logic beq;
    logic bne;
    logic j;
    logic imm;
    logic imm_unsigned;
    logic illegal;
  } op_class_t;

  function automatic logic [3:0] alu_imm(input logic [5:0] op);
    return {1'b1, op[2:0]};
  endfunction

endpackage

// File: rtl/multi_cycle_control_fsm_if.sv
// Controller <-> datapath bundle: IR opcode and memory ready in,
// datapath enables and mux selects out.
interface multi_cycle_control_fsm_if;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       PCWrite;
  logic       PCWriteCond;
  logic       PCWriteCondNE;
  logic [1:0] PCSource;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegDst;
  logic       MemtoReg;
  logic       RegWrite;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [3:0] ALUop;
  logic       Unsigned;
  logic       instr_done;
  logic       illegal_op;

  modport master (
    input  opcode, mem_ready,
    output PCWrite, PCWriteCond, PCWriteCondNE, PCSource,
    output IorD, MemRead, MemWrite, IRWrite,
    output RegDst, MemtoReg, RegWrite,
    output ALUSrcA, ALUSrcB, ALUop, Unsigned,
    output instr_done, illegal_op
  );

  modport slave (
    output opcode, mem_ready,
    input  PCWrite, PCWriteCond, PCWriteCondNE, PCSource,
    input  IorD, MemRead, MemWrite, IRWrite,
    input  RegDst, MemtoReg, RegWrite,
    input  ALUSrcA, ALUSrcB, ALUop, Unsigned,
    input  instr_done, illegal_op
  );
endinterface

// File: rtl/multi_cycle_control_fsm_decode.sv
// Combinational opcode classifier; exactly one class bit is set.
module mc_opcode_decode
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  output op_class_t  cls
);

  always_comb begin
    cls = '0;
    unique case (1'b1)
      (opcode == OP_RTYPE): cls.rtype = 1'b1;
      (opcode == OP_LW):    cls.lw    = 1'b1;
      (opcode == OP_SW):    cls.sw    = 1'b1;
      (opcode == OP_BEQ):   cls.beq   = 1'b1;
      (opcode == OP_BNE):   cls.bne   = 1'b1;
      (opcode == OP_J):     cls.j     = 1'b1;
      (opcode == OP_ADDIU),
      (opcode == OP_SLTIU): cls.imm_unsigned = 1'b1;
      (opcode == OP_ADDI),
      (opcode == OP_SLTI),
      (opcode == OP_ANDI),
      (opcode == OP_ORI):   cls.imm = 1'b1;
      default:              cls.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multi_cycle_control_fsm.sv
// Multi-cycle MIPS sequencer: state register, next-state logic and
// Moore output decode (only FETCH/MEM_WRITE look at mem_ready).
module multi_cycle_control_fsm
  import mc_ctrl_pkg::*;
#(
  parameter bit USE_MEM_READY = 1'b1,
  parameter int STATE_W       = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  multi_cycle_control_fsm_if.master  bus
);

  typedef enum logic [STATE_W-1:0] {
    ST_RST       = STATE_W'(S_RST),
    ST_FETCH     = STATE_W'(S_FETCH),
    ST_DECODE    = STATE_W'(S_DECODE),
    ST_MEM_ADDR  = STATE_W'(S_MEM_ADDR),
    ST_MEM_READ  = STATE_W'(S_MEM_READ),
    ST_MEM_WB    = STATE_W'(S_MEM_WB),
    ST_MEM_WRITE = STATE_W'(S_MEM_WRITE),
    ST_R_EXEC    = STATE_W'(S_R_EXEC),
    ST_R_WB      = STATE_W'(S_R_WB),
    ST_I_EXEC    = STATE_W'(S_I_EXEC),
    ST_I_WB      = STATE_W'(S_I_WB),
    ST_BRANCH    = STATE_W'(S_BRANCH),
    ST_JUMP      = STATE_W'(S_JUMP),
    ST_ILLEGAL   = STATE_W'(S_ILLEGAL)
  } state_e;

  state_e    state;
  op_class_t cls;
  logic      ready;

  assign ready = USE_MEM_READY ? bus.mem_ready : 1'b1;

  mc_opcode_decode u_dec (
    .opcode (bus.opcode),
    .cls    (cls)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_RST;
    end else begin
      unique case (state)
        ST_RST:       state <= ST_FETCH;
        ST_FETCH:     if (ready) state <= ST_DECODE;
        ST_DECODE: begin
          unique case (1'b1)
            cls.rtype:                state <= ST_R_EXEC;
            cls.lw, cls.sw:           state <= ST_MEM_ADDR;
            cls.beq, cls.bne:         state <= ST_BRANCH;
            cls.j:                    state <= ST_JUMP;
            cls.imm, cls.imm_unsigned: state <= ST_I_EXEC;
            cls.illegal:              state <= ST_ILLEGAL;
            default:                  state <= ST_ILLEGAL;
          endcase
        end
        ST_MEM_ADDR:  state <= cls.lw ? ST_MEM_READ : ST_MEM_WRITE;
        ST_MEM_READ:  if (ready) state <= ST_MEM_WB;
        ST_MEM_WRITE: if (ready) state <= ST_FETCH;
        ST_R_EXEC:    state <= ST_R_WB;
        ST_I_EXEC:    state <= ST_I_WB;
        ST_ILLEGAL:   state <= ST_ILLEGAL;
        ST_MEM_WB, ST_R_WB, ST_I_WB,
        ST_BRANCH, ST_JUMP:
                      state <= ST_FETCH;
        default:      state <= ST_RST;
      endcase
    end
  end

  always_comb begin
    bus.PCWrite       = 1'b0;
    bus.PCWriteCond   = 1'b0;
    bus.PCWriteCondNE = 1'b0;
    bus.PCSource      = PCS_ALU;
    bus.IorD          = 1'b0;
    bus.MemRead       = 1'b0;
    bus.MemWrite      = 1'b0;
    bus.IRWrite       = 1'b0;
    bus.RegDst        = 1'b0;
    bus.MemtoReg      = 1'b0;
    bus.RegWrite      = 1'b0;
    bus.ALUSrcA       = 1'b0;
    bus.ALUSrcB       = SRCB_REG;
    bus.ALUop         = ALU_ADD;
    bus.Unsigned      = 1'b0;
    bus.instr_done    = 1'b0;
    bus.illegal_op    = 1'b0;
    unique case (state)
      ST_FETCH: begin
        bus.MemRead = 1'b1;
        bus.ALUSrcB = SRCB_FOUR;
        bus.IRWrite = ready;
        bus.PCWrite = ready;
      end
      ST_DECODE:  bus.ALUSrcB = SRCB_IMMS;
      ST_MEM_ADDR: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUSrcB = SRCB_IMM;
      end
      ST_MEM_READ: begin
        bus.MemRead = 1'b1;
        bus.IorD    = 1'b1;
      end
      ST_MEM_WB: begin
        bus.RegWrite   = 1'b1;
        bus.MemtoReg   = 1'b1;
        bus.instr_done = 1'b1;
      end
      ST_MEM_WRITE: begin
        bus.MemWrite   = 1'b1;
        bus.IorD       = 1'b1;
        bus.instr_done = ready;
      end
      ST_R_EXEC: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUop   = ALU_RTYPE;
      end
      ST_R_WB: begin
        bus.RegWrite   = 1'b1;
        bus.RegDst     = 1'b1;
        bus.instr_done = 1'b1;
      end
      ST_I_EXEC: begin
        bus.ALUSrcA  = 1'b1;
        bus.ALUSrcB  = SRCB_IMM;
        bus.ALUop    = alu_imm(bus.opcode);
        bus.Unsigned = cls.imm_unsigned;
      end
      ST_I_WB: begin
        bus.RegWrite   = 1'b1;
        bus.instr_done = 1'b1;
      end
      ST_BRANCH: begin
        bus.ALUSrcA       = 1'b1;
        bus.ALUop         = ALU_SUB;
        bus.PCSource      = PCS_ALUOUT;
        bus.PCWriteCond   = cls.beq;
        bus.PCWriteCondNE = cls.bne;
        bus.instr_done    = 1'b1;
      end
      ST_JUMP: begin
        bus.PCWrite    = 1'b1;
        bus.PCSource   = PCS_JUMP;
        bus.instr_done = 1'b1;
      end
      ST_ILLEGAL: bus.illegal_op = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multi_cycle_control_fsm.sv
// Randomized scoreboard bench for multi_cycle_control_fsm: expected
// control words are queued per cycle and checked by a separate monitor.
module tb_multi_cycle_control_fsm;

  typedef struct packed {
    logic       PCWrite;
    logic       PCWriteCond;
    logic       PCWriteCondNE;
    logic [1:0] PCSource;
    logic       IorD;
    logic       MemRead;
    logic       MemWrite;
    logic       IRWrite;
    logic       RegDst;
    logic       MemtoReg;
    logic       RegWrite;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [3:0] ALUop;
    logic       Unsigned;
    logic       instr_done;
    logic       illegal_op;
  } ctl_t;

  typedef enum int {
    P_IDLE, P_FETCH, P_DEC, P_ADDR, P_READ, P_LWB, P_WRITE,
    P_REX, P_RWB, P_IEX, P_IWB, P_BR, P_JMP, P_ILL
  } phase_e;

  typedef struct {
    ctl_t   w;
    phase_e ph;
    int     op;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;
  exp_t exp_q[$];
  ctl_t act;

  multi_cycle_control_fsm_if bus ();

  multi_cycle_control_fsm #(
    .USE_MEM_READY (1'b1),
    .STATE_W       (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  assign act = {bus.PCWrite, bus.PCWriteCond, bus.PCWriteCondNE,
                bus.PCSource, bus.IorD, bus.MemRead, bus.MemWrite,
                bus.IRWrite, bus.RegDst, bus.MemtoReg, bus.RegWrite,
                bus.ALUSrcA, bus.ALUSrcB, bus.ALUop, bus.Unsigned,
                bus.instr_done, bus.illegal_op};

  // Reference: what each phase of an instruction must drive.
  function automatic ctl_t model(phase_e ph, int op, bit rdy);
    ctl_t w = '0;
    logic [5:0] o = op[5:0];
    case (ph)
      P_FETCH: begin
        w.MemRead = 1; w.ALUSrcB = 2'b01;
        w.IRWrite = rdy; w.PCWrite = rdy;
      end
      P_DEC:   w.ALUSrcB = 2'b11;
      P_ADDR:  begin w.ALUSrcA = 1; w.ALUSrcB = 2'b10; end
      P_READ:  begin w.MemRead = 1; w.IorD = 1; end
      P_LWB:   begin w.RegWrite = 1; w.MemtoReg = 1; w.instr_done = 1; end
      P_WRITE: begin w.MemWrite = 1; w.IorD = 1; w.instr_done = rdy; end
      P_REX:   begin w.ALUSrcA = 1; w.ALUop = 4'b0010; end
      P_RWB:   begin w.RegWrite = 1; w.RegDst = 1; w.instr_done = 1; end
      P_IEX: begin
        w.ALUSrcA = 1; w.ALUSrcB = 2'b10;
        w.ALUop = {1'b1, o[2:0]};
        w.Unsigned = (op == 9) || (op == 11);
      end
      P_IWB:   begin w.RegWrite = 1; w.instr_done = 1; end
      P_BR: begin
        w.ALUSrcA = 1; w.ALUop = 4'b0001; w.PCSource = 2'b01;
        w.PCWriteCond = (op == 4); w.PCWriteCondNE = (op == 5);
        w.instr_done = 1;
      end
      P_JMP:   begin w.PCWrite = 1; w.PCSource = 2'b10; w.instr_done = 1; end
      P_ILL:   w.illegal_op = 1;
      default: ;
    endcase
    return w;
  endfunction

  task automatic step(phase_e ph, int op, bit rdy);
    exp_t e;
    @(posedge clk);
    #1;
    bus.opcode = op[5:0];
    bus.mem_ready = rdy;
    e.w = model(ph, op, rdy);
    e.ph = ph;
    e.op = op;
    exp_q.push_back(e);
  endtask

  task automatic do_reset(int n);
    exp_t e;
    e.w = '0;
    e.ph = P_IDLE;
    e.op = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      reset = 1'b1;
      bus.mem_ready = 1'($urandom);
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    exp_q.push_back(e);
  endtask

  function automatic int rnd_op();
    return int'($urandom_range(0, 63));
  endfunction

  task automatic run_instr(int op, int fw, int mw);
    for (int i = 0; i < fw; i++) step(P_FETCH, rnd_op(), 1'b0);
    step(P_FETCH, rnd_op(), 1'b1);
    step(P_DEC, op, 1'($urandom));
    if (op == 0) begin
      step(P_REX, op, 1'($urandom));
      step(P_RWB, op, 1'($urandom));
    end else if (op == 35) begin
      step(P_ADDR, op, 1'($urandom));
      for (int i = 0; i < mw; i++) step(P_READ, op, 1'b0);
      step(P_READ, op, 1'b1);
      step(P_LWB, op, 1'($urandom));
    end else if (op == 43) begin
      step(P_ADDR, op, 1'($urandom));
      for (int i = 0; i < mw; i++) step(P_WRITE, op, 1'b0);
      step(P_WRITE, op, 1'b1);
    end else if (op == 4 || op == 5) begin
      step(P_BR, op, 1'($urandom));
    end else if (op == 2) begin
      step(P_JMP, op, 1'($urandom));
    end else if (op >= 8 && op <= 13) begin
      step(P_IEX, op, 1'($urandom));
      step(P_IWB, op, 1'($urandom));
    end else begin
      for (int i = 0; i < 20; i++) step(P_ILL, op, 1'($urandom));
      do_reset(1 + int'($urandom_range(0, 2)));
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (act !== e.w) begin
          errors++;
          $display("FAIL ctl_word phase=%s op=%0d got=%h want=%h",
                   e.ph.name(), e.op, act, e.w);
        end
        checks++;
        if (act.MemRead && act.MemWrite ||
            act.RegWrite && (act.MemRead || act.MemWrite)) begin
          errors++;
          $display("FAIL strobe_excl phase=%s got=%h want=no overlap",
                   e.ph.name(), act);
        end
      end
    end
  end

  initial begin : stim
    int legal[12] = '{0, 35, 43, 4, 5, 2, 8, 9, 10, 11, 12, 13};
    int op;
    bus.opcode = '0;
    bus.mem_ready = 1'b0;
    do_reset(3);
    run_instr(0, 0, 0);
    run_instr(35, 0, 2);
    run_instr(11, 1, 0);
    run_instr(5, 0, 0);
    run_instr(2, 0, 0);
    run_instr(4, 2, 0);
    // sw stalled in MEM_WRITE, then reset lands mid-instruction
    step(P_FETCH, rnd_op(), 1'b1);
    step(P_DEC, 43, 1'b0);
    step(P_ADDR, 43, 1'b0);
    step(P_WRITE, 43, 1'b0);
    step(P_WRITE, 43, 1'b0);
    do_reset(2);
    run_instr(0, 3, 0);
    run_instr(63, 0, 0);
    run_instr(43, 0, 1);
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 9) == 0) op = rnd_op();
      else op = legal[$urandom_range(0, 11)];
      run_instr(op, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
    end
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got=%0d want=0 pending", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
